// File: rtl/mask_stream_shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mask_stream_shifter_pkg
// Description : Shared constants and bit-manipulation helpers for the
//               mask_stream_shifter packing stage.
//               PKG_DW : widest sample width the helpers support
//               CW     : width of a bit count in the range 0..PKG_DW
//               popcount() : number of set bits in a vector
//               compact()  : gather mask-selected bits toward the LSB
// Revision    : 1.0 - initial release
// ============================================================================
package mask_stream_shifter_pkg;

    localparam int PKG_DW = 32;
    localparam int CW     = $clog2(PKG_DW + 1);

    function automatic logic [CW-1:0] popcount(input logic [PKG_DW-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < PKG_DW; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // Selected bits land in ascending order starting at bit 0. The write
    // position is applied as a shift so no variable bit-select is needed.
    function automatic logic [PKG_DW-1:0] compact(input logic [PKG_DW-1:0] d,
                                                  input logic [PKG_DW-1:0] m);
        logic [PKG_DW-1:0] r;
        logic [CW-1:0]     k;
        r = '0;
        k = '0;
        for (int i = 0; i < PKG_DW; i++) begin
            if (m[i]) begin
                r = r | (PKG_DW'(d[i]) << k);
                k = k + CW'(1);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mask_stream_shifter_bit_compactor.sv
`default_nettype none
// ============================================================================
// Module      : bit_compactor
// Description : Combinational mask-driven bit gather.
//               data    in  DW  : input sample
//               mask    in  DW  : bit i = 1 keeps data bit i
//               compact out DW  : kept bits packed at [count-1:0], rest 0
//               count   out CW  : number of kept bits (popcount of mask)
//               DW must not exceed PKG_DW.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_compactor
    import mask_stream_shifter_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] data,
    input  logic [DW-1:0] mask,
    output logic [DW-1:0] compact,
    output logic [CW-1:0] count
);

    logic [PKG_DW-1:0] w_data_ext;
    logic [PKG_DW-1:0] w_mask_ext;
    logic [PKG_DW-1:0] w_compact_ext;

    assign w_data_ext    = PKG_DW'(data);
    assign w_mask_ext    = PKG_DW'(mask);
    assign w_compact_ext = mask_stream_shifter_pkg::compact(w_data_ext, w_mask_ext);
    assign compact       = w_compact_ext[DW-1:0];
    assign count         = popcount(w_mask_ext);

endmodule
`default_nettype wire

// File: rtl/mask_stream_shifter.sv
`default_nettype none
// ============================================================================
// Module      : mask_stream_shifter
// Description : Stream packing stage. Bypass passes samples through; compact
//               mode gathers mask-selected bits of each sample and packs
//               K = DW/N consecutive compacted samples into one output word.
//               clk       in  1   : system clock, rising edge
//               rst       in  1   : synchronous active-high reset
//               ctl_ena   in  1   : 0 = bypass, 1 = compact/pack
//               ctl_clr   in  1   : synchronous clear of packing state
//               cfg_mask  in  DW  : bit-select mask
//               sti_data  in  DW  : input sample
//               sti_valid in  1   : input valid
//               sti_ready out 1   : input ready
//               sto_data  out DW  : output word
//               sto_valid out 1   : output valid
//               sto_ready in  1   : downstream ready
// Revision    : 1.0 - initial release
// ============================================================================
module mask_stream_shifter
    import mask_stream_shifter_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ctl_ena,
    input  logic          ctl_clr,
    input  logic [DW-1:0] cfg_mask,
    input  logic [DW-1:0] sti_data,
    input  logic          sti_valid,
    output logic          sti_ready,
    output logic [DW-1:0] sto_data,
    output logic          sto_valid,
    input  logic          sto_ready
);

    localparam int SW = 2 * CW;

    logic [DW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_data;
    logic          r_valid;

    logic [DW-1:0] w_compact;
    logic [CW-1:0] w_n;
    logic [CW-1:0] w_k;
    logic          w_accept;
    logic          w_last;
    logic [SW-1:0] w_sh;
    logic [DW-1:0] w_placed;

    bit_compactor #(
        .DW (DW)
    ) u_bit_compactor (
        .data    (sti_data),
        .mask    (cfg_mask),
        .compact (w_compact),
        .count   (w_n)
    );

    // K = DW / N as the largest q with q*N <= DW. N = 0 yields DW, which is
    // harmless because zero-width samples are dropped before packing.
    always_comb begin
        w_k = '0;
        for (int q = 1; q <= DW; q++) begin
            if (q * int'(w_n) <= DW) begin
                w_k = CW'(q);
            end
        end
    end

    // A count at or beyond K-1 (possible after an unflushed reconfiguration)
    // closes the word in the last slot of the new geometry.
    assign w_last   = (r_cnt >= (w_k - CW'(1)));
    assign w_sh     = (w_last ? SW'(w_k - CW'(1)) : SW'(r_cnt)) * SW'(w_n);
    assign w_placed = w_compact << w_sh;

    assign sti_ready = ~ctl_clr & (~r_valid | sto_ready);
    assign w_accept  = sti_valid & sti_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (ctl_clr) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            if (r_valid && sto_ready) begin
                r_valid <= 1'b0;
            end
            if (w_accept) begin
                if (!ctl_ena) begin
                    r_data  <= sti_data;
                    r_valid <= 1'b1;
                end else if (w_n != '0) begin
                    if (w_last) begin
                        r_data  <= r_acc | w_placed;
                        r_valid <= 1'b1;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_acc <= r_acc | w_placed;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            end
        end
    end

    assign sto_data  = r_data;
    assign sto_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_mask_stream_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mask_stream_shifter
// Description : Directed self-checking bench for mask_stream_shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mask_stream_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctl_ena;
    logic        ctl_clr;
    logic [31:0] cfg_mask;
    logic [31:0] sti_data;
    logic        sti_valid;
    logic        sti_ready;
    logic [31:0] sto_data;
    logic        sto_valid;
    logic        sto_ready;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] outq[$];
    int          outc[$];
    int          valid_seen = 0;
    int          stall_seen = 0;
    int          stall_err = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    mask_stream_shifter #(
        .DW (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ctl_ena   (ctl_ena),
        .ctl_clr   (ctl_clr),
        .cfg_mask  (cfg_mask),
        .sti_data  (sti_data),
        .sti_valid (sti_valid),
        .sti_ready (sti_ready),
        .sto_data  (sto_data),
        .sto_valid (sto_valid),
        .sto_ready (sto_ready)
    );

    always #5 clk = ~clk;

    // Output observer: inputs change only just after posedge, so values seen
    // at negedge are the ones the next posedge acts on.
    always @(negedge clk) begin
        cyc++;
        if (prev_stall && !(sto_valid === 1'b1 && sto_data === prev_data)) begin
            stall_err++;
        end
        prev_stall = (rst === 1'b0) && (ctl_clr === 1'b0) && sto_valid && !sto_ready;
        if (prev_stall) stall_seen++;
        prev_data = sto_data;
        if (sto_valid === 1'b1) valid_seen++;
        if (sto_valid === 1'b1 && sto_ready === 1'b1) begin
            outq.push_back(sto_data);
            outc.push_back(cyc);
        end
    end

    task automatic send(input logic [31:0] d, output int acc_cyc);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        acc_cyc = -1;
        sti_data = d;
        sti_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            #1;
            if (sti_ready === 1'b1) begin
                acc_cyc = cyc;
                done = 1'b1;
            end else begin
                n++;
                if (n > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: data=%h not accepted, waited %0d cycles, required <= 50", d, n);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        sti_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_state();
        ctl_clr = 1'b1;
        @(posedge clk);
        #1;
        ctl_clr = 1'b0;
        outq.delete();
        outc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ctl_ena = 1'b0;
        ctl_clr = 1'b0;
        cfg_mask = '0;
        sti_data = '0;
        sti_valid = 1'b0;
        sto_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sto_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b, expected 0", sto_valid);
        end
        checks++;
        if (sto_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h, expected 00000000", sto_data);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (sti_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, expected 1", sti_ready);
        end
    endtask

    task automatic test_bypass();
        int start;
        int a;
        int first_acc;
        logic [31:0] exp;
        ctl_ena = 1'b0;
        cfg_mask = 32'hFFFF_FFFF;
        sto_ready = 1'b1;
        clear_state();
        start = cyc;
        first_acc = -1;
        for (int i = 0; i < 16; i++) begin
            send(32'(i) * 32'h1111_1111, a);
            if (i == 0) first_acc = a;
        end
        drain(4);
        checks++;
        if (outq.size() != 16) begin
            errors++;
            $display("FAIL bypass_count: got %0d words, expected 16", outq.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                exp = 32'(i) * 32'h1111_1111;
                checks++;
                if (outq[i] !== exp) begin
                    errors++;
                    $display("FAIL bypass_word[%0d]: got %h, expected %h", i, outq[i], exp);
                end
            end
            checks++;
            if (outc[0] != first_acc + 1) begin
                errors++;
                $display("FAIL bypass_latency: output cycle %0d, expected %0d", outc[0], first_acc + 1);
            end
            checks++;
            if (outc[15] - start >= 128) begin
                errors++;
                $display("FAIL bypass_duration: took %0d cycles, expected < 128", outc[15] - start);
            end
        end
    endtask

    task automatic test_bypass_backpressure();
        int a;
        int t;
        bit bp_done;
        logic [31:0] exp;
        ctl_ena = 1'b0;
        cfg_mask = 32'hFFFF_FFFF;
        sto_ready = 1'b1;
        clear_state();
        stall_err = 0;
        stall_seen = 0;
        bp_done = 1'b0;
        fork
            begin
                int k;
                k = 0;
                while (!bp_done) begin
                    sto_ready = (k % 3 == 0);
                    k++;
                    @(posedge clk);
                    #1;
                end
            end
            begin
                for (int i = 0; i < 16; i++) begin
                    send(32'(i) * 32'h1111_1111, a);
                end
                t = 0;
                while (outq.size() < 16 && t < 300) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                bp_done = 1'b1;
            end
        join
        sto_ready = 1'b1;
        drain(4);
        checks++;
        if (outq.size() != 16) begin
            errors++;
            $display("FAIL bp_count: got %0d words, expected 16", outq.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                exp = 32'(i) * 32'h1111_1111;
                checks++;
                if (outq[i] !== exp) begin
                    errors++;
                    $display("FAIL bp_word[%0d]: got %h, expected %h", i, outq[i], exp);
                end
            end
        end
        checks++;
        if (stall_err != 0 || stall_seen == 0) begin
            errors++;
            $display("FAIL bp_stable: unstable stalls %0d (expected 0), stalls seen %0d (expected > 0)",
                     stall_err, stall_seen);
        end
    endtask

    task automatic test_pack8();
        int a;
        ctl_ena = 1'b1;
        cfg_mask = 32'h0000_00FF;
        sto_ready = 1'b1;
        clear_state();
        send(32'h11, a);
        send(32'h22, a);
        send(32'h33, a);
        send(32'h44, a);
        drain(4);
        checks++;
        if (outq.size() != 1) begin
            errors++;
            $display("FAIL pack8_count: got %0d words, expected 1", outq.size());
        end else begin
            checks++;
            if (outq[0] !== 32'h4433_2211) begin
                errors++;
                $display("FAIL pack8_word: got %h, expected 44332211", outq[0]);
            end
            checks++;
            if (outc[0] != a + 1) begin
                errors++;
                $display("FAIL pack8_latency: output cycle %0d, expected %0d", outc[0], a + 1);
            end
        end
    endtask

    task automatic test_scattered();
        int a;
        ctl_ena = 1'b1;
        sto_ready = 1'b1;
        cfg_mask = 32'h0000_F00F;
        clear_state();
        repeat (4) send(32'h0000_A00B, a);
        drain(4);
        checks++;
        if (outq.size() != 1 || outq[0] !== 32'hABAB_ABAB) begin
            errors++;
            $display("FAIL scatter_word: got %0d words first %h, expected 1 word ABABABAB",
                     outq.size(), (outq.size() > 0) ? outq[0] : 32'h0);
        end
        cfg_mask = 32'h0000_0FFF;
        clear_state();
        send(32'h123, a);
        send(32'h456, a);
        drain(4);
        checks++;
        if (outq.size() != 1 || outq[0] !== 32'h0045_6123) begin
            errors++;
            $display("FAIL k2_word: got %0d words first %h, expected 1 word 00456123",
                     outq.size(), (outq.size() > 0) ? outq[0] : 32'h0);
        end
    endtask

    task automatic test_clear_mid_word();
        int a;
        ctl_ena = 1'b1;
        cfg_mask = 32'h0000_00FF;
        sto_ready = 1'b1;
        clear_state();
        send(32'hAA, a);
        send(32'hBB, a);
        ctl_clr = 1'b1;
        sti_data = 32'hEE;
        sti_valid = 1'b1;
        #1;
        checks++;
        if (sti_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_ready: got %b, expected 0", sti_ready);
        end
        @(posedge clk);
        #1;
        ctl_clr = 1'b0;
        sti_valid = 1'b0;
        for (int i = 1; i <= 4; i++) send(32'(i), a);
        drain(4);
        checks++;
        if (outq.size() != 1 || outq[0] !== 32'h0403_0201) begin
            errors++;
            $display("FAIL clr_word: got %0d words first %h, expected 1 word 04030201",
                     outq.size(), (outq.size() > 0) ? outq[0] : 32'h0);
        end
    endtask

    task automatic test_reset_mid_word();
        int a;
        ctl_ena = 1'b1;
        cfg_mask = 32'h0000_00FF;
        sto_ready = 1'b1;
        clear_state();
        send(32'hAA, a);
        send(32'hBB, a);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (sto_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_valid: got %b, expected 0", sto_valid);
        end
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) send(32'(i), a);
        drain(4);
        checks++;
        if (outq.size() != 1 || outq[0] !== 32'h0403_0201) begin
            errors++;
            $display("FAIL rst_mid_word: got %0d words first %h, expected 1 word 04030201",
                     outq.size(), (outq.size() > 0) ? outq[0] : 32'h0);
        end
    endtask

    task automatic test_zero_mask();
        int a;
        int accepted;
        ctl_ena = 1'b1;
        cfg_mask = 32'h0;
        sto_ready = 1'b1;
        clear_state();
        valid_seen = 0;
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            send(32'hFFFF_0000 | 32'(i), a);
            if (a >= 0) accepted++;
        end
        drain(4);
        checks++;
        if (accepted != 8) begin
            errors++;
            $display("FAIL zero_accepted: got %0d, expected 8", accepted);
        end
        checks++;
        if (valid_seen != 0) begin
            errors++;
            $display("FAIL zero_valid: sto_valid high %0d cycles, expected 0", valid_seen);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_bypass_backpressure();
        test_pack8();
        test_scattered();
        test_clear_mid_word();
        test_reset_mid_word();
        test_zero_mask();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mask_stream_shifter.md
Name: mask_stream_shifter

Overview:
- Stream-path packing stage of the logic-analyzer capture pipeline, between sample source and downstream buffer.
- With the shifter disabled, samples pass through unchanged.
- With it enabled, the bits of each sample selected by `cfg_mask` are compacted toward the LSB. Consecutive compacted samples are packed into full DW-bit output words.
- Valid/ready streams on both sides.

Parameters:
- DW, 32, data width of input samples, output words and mask.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ctl_ena  in  1  0 = bypass, 1 = compact/pack mode.
- ctl_clr  in  1  synchronous clear of packing state.
- cfg_mask  in  DW  bit-select mask; bit i = 1 keeps sample bit i.
- sti_data  in  DW  input sample.
- sti_valid  in  1  input sample valid.
- sti_ready  out  1  input accepted when sti_valid & sti_ready.
- sto_data  out  DW  output word.
- sto_valid  out  1  output word valid.
- sto_ready  in  1  downstream accepts when sto_valid & sto_ready.

Behaviour:
- Interface clocking: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: sto_valid=0, sto_data=0, accumulator=0, sample counter=0. rst has priority over everything, including mid-word; partial words are discarded.
- Output register: one register stage (sto_data/sto_valid).
  - sti_ready = ~sto_valid | sto_ready (combinational).
  - Output transfer when sto_valid & sto_ready.
  - sto_valid stays high and sto_data holds stable until transfer.
- Bypass (ctl_ena=0):
  - Each accepted sample is loaded into the output register the next cycle.
  - Latency 1 cycle, throughput 1 word/cycle with sto_ready held high.
  - Order preserved; no loss or duplication under backpressure.
  - cfg_mask is ignored.
- Compact mode (ctl_ena=1):
  - N = popcount(cfg_mask), range 0..DW.
  - compact = sti_data bits at mask-1 positions, in ascending bit order, placed at bits [N-1:0]; upper bits 0.
  - K = DW / N (integer division) samples per output word.
  - Sample j of a word (j = 0..K-1) occupies bits [j*N +: N]. Bits at K*N and above are 0.
  - On each accepted sample with cnt < K-1: acc |= compact << (cnt*N); cnt++.
  - On the K-th accepted sample: output register <= acc | (compact << ((K-1)*N)); sto_valid <= 1; acc <= 0; cnt <= 0. The word appears 1 cycle after the K-th accept.
  - N = DW (all-ones mask): identical to bypass timing and data.
  - N = 0: inputs accepted (sti_ready per rule above) and dropped; no output ever produced.
- ctl_clr (when rst=0):
  - Clears acc and cnt, and sets sto_valid=0.
  - An input presented in the same cycle is not accepted: sti_ready forced 0 while ctl_clr=1.
  - Priority: rst > ctl_clr > normal operation.
- Configuration changes:
  - Software changes ctl_ena/cfg_mask only when idle, followed by ctl_clr.
  - A change without ctl_clr takes effect on the next accepted sample using the new N/K. The partial accumulator is kept as-is; no error flagged.
- Width rules:
  - cnt is $clog2(DW+1) bits.
  - Shift amounts are computed at full width; no truncation of compact into unused bits.

Decomposition:
- Package mask_stream_shifter_pkg:
  - popcount function.
  - compact function (mask-driven bit gather, loop-based).
  - Localparam CW = $clog2(DW+1).
- One combinational sub-module, bit_compactor (params DW; in data, mask; out compact, count). Instantiated once.
- Packing accumulator, divide (K from N, small-range lookup or loop), and output register live in the top.

Test Plan:
- Bypass: ctl_ena=0, cfg_mask=all-ones, DW=32, 16 words 0x00000000, 0x11111111 … 0xFFFFFFFF, drain always ready -> identical 16 words in order, error count 0, completes well under 128 cycles.
- Bypass backpressure: same 16 words, sto_ready toggled 1-of-3 cycles -> same 16 words, none lost or duplicated; sto_data stable while stalled.
- Pack N=8: ctl_ena=1, cfg_mask=0x000000FF, inputs 0x11, 0x22, 0x33, 0x44 -> exactly one output 0x44332211, 1 cycle after the 4th accept.
- Scattered mask and non-dividing N:
  - cfg_mask=0x0000F00F, four inputs 0x0000A00B -> 0xABABABAB.
  - cfg_mask=0x00000FFF (K=2), inputs 0x123, 0x456 -> 0x00456123.
- Clear/reset mid-word: cfg_mask=0xFF, send 0xAA, 0xBB, pulse ctl_clr, send 0x01..0x04 -> only 0x04030201. Repeat with rst pulse instead of ctl_clr -> same result, sto_valid=0 during reset.
- Zero mask: cfg_mask=0, 8 inputs -> all accepted, sto_valid never asserted.
